// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the two regfile write ports among NUM_REQ writeback requesters.
// Up to two grants per cycle, never two to the same register; granted writes are registered.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_num,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      write0,
    output logic [REG_AW-1:0]         num_write0_out,
    output logic [DATA_W-1:0]         data_write0_out,
    output logic                      write1,
    output logic [REG_AW-1:0]         num_write1_out,
    output logic [DATA_W-1:0]         data_write1_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  rr_ptr_next;

    logic [REG_AW-1:0] num_arr  [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [PTR_W-1:0]  scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_valid;

    logic              slot0_found;
    logic              slot1_found;
    logic [PTR_W-1:0]  slot0_idx;
    logic [PTR_W-1:0]  slot1_idx;
    logic              grant_en;
    logic              grant0;
    logic              grant1;

    logic              write0_reg;
    logic              write1_reg;
    logic [REG_AW-1:0] num0_reg;
    logic [REG_AW-1:0] num1_reg;
    logic [DATA_W-1:0] data0_reg;
    logic [DATA_W-1:0] data1_reg;

    // Scan position gi visits requester (rr_ptr + gi) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [PTR_W:0] sum;
            logic [PTR_W:0] wrapped;

            assign num_arr[gi]  = req_num[gi*REG_AW +: REG_AW];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
            assign sum          = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
            assign wrapped      = sum - NUM_REQ_W;
            assign scan_idx[gi] = (sum >= NUM_REQ_W) ? wrapped[PTR_W-1:0] : sum[PTR_W-1:0];
            assign rot_valid[gi] = req_valid[scan_idx[gi]];
        end
    endgenerate

    // slot1 skips requesters that collide with slot0's register; they stay pending.
    always_comb begin
        slot0_found = 1'b0;
        slot1_found = 1'b0;
        slot0_idx   = '0;
        slot1_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rot_valid[k]) begin
                if (!slot0_found) begin
                    slot0_found = 1'b1;
                    slot0_idx   = scan_idx[k];
                end else if (!slot1_found && (num_arr[scan_idx[k]] != num_arr[slot0_idx])) begin
                    slot1_found = 1'b1;
                    slot1_idx   = scan_idx[k];
                end
            end
        end
    end

    assign grant_en = rst & ~stall;
    assign grant0   = slot0_found & grant_en;
    assign grant1   = slot1_found & grant_en;

    always_comb begin
        req_ready = '0;
        if (grant0) begin
            req_ready[slot0_idx] = 1'b1;
        end
        if (grant1) begin
            req_ready[slot1_idx] = 1'b1;
        end
    end

    // Pointer moves just past the last granted requester.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant1) begin
            rr_ptr_next = (slot1_idx == LAST_IDX) ? '0 : slot1_idx + PTR_W'(1);
        end else if (grant0) begin
            rr_ptr_next = (slot0_idx == LAST_IDX) ? '0 : slot0_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
            write0_reg <= 1'b0;
            write1_reg <= 1'b0;
            num0_reg   <= '0;
            num1_reg   <= '0;
            data0_reg  <= '0;
            data1_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            write0_reg <= grant0;
            write1_reg <= grant1;
            if (grant0) begin
                num0_reg  <= num_arr[slot0_idx];
                data0_reg <= data_arr[slot0_idx];
            end
            if (grant1) begin
                num1_reg  <= num_arr[slot1_idx];
                data1_reg <= data_arr[slot1_idx];
            end
        end
    end

    assign write0          = write0_reg;
    assign num_write0_out  = num0_reg;
    assign data_write0_out = data0_reg;
    assign write1          = write1_reg;
    assign num_write1_out  = num1_reg;
    assign data_write1_out = data1_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_num = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            write0, write1;
    logic [AW-1:0]   num_write0_out, num_write1_out;
    logic [DW-1:0]   data_write0_out, data_write1_out;

    int vectors = 0;
    int miscompares = 0;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_num(req_num), .req_data(req_data),
        .req_ready(req_ready),
        .write0(write0), .num_write0_out(num_write0_out), .data_write0_out(data_write0_out),
        .write1(write1), .num_write1_out(num_write1_out), .data_write1_out(data_write1_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected grants from the scan rules, expected port registers.
    initial begin : model
        int m_ptr;
        int g0, g1, idx;
        logic m_w0, m_w1;
        logic [AW-1:0] m_n0, m_n1;
        logic [DW-1:0] m_d0, m_d1;
        logic [N-1:0] er;
        logic [N*AW-1:0] s_num;
        logic [N*DW-1:0] s_data;
        m_ptr = 0;
        m_w0 = 0; m_w1 = 0; m_n0 = '0; m_n1 = '0; m_d0 = '0; m_d1 = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_ptr = 0;
                m_w0 = 0; m_w1 = 0; m_n0 = '0; m_n1 = '0; m_d0 = '0; m_d1 = '0;
            end
            check("model_port0", {write0, num_write0_out, data_write0_out}, {m_w0, m_n0, m_d0});
            check("model_port1", {write1, num_write1_out, data_write1_out}, {m_w1, m_n1, m_d1});
            g0 = -1;
            g1 = -1;
            s_num  = req_num;
            s_data = req_data;
            if (rst && !stall) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (req_valid[idx]) begin
                        if (g0 < 0) g0 = idx;
                        else if (g1 < 0 && s_num[idx*AW +: AW] != s_num[g0*AW +: AW]) g1 = idx;
                    end
                end
            end
            er = '0;
            if (g0 >= 0) er[g0] = 1'b1;
            if (g1 >= 0) er[g1] = 1'b1;
            check("model_ready", req_ready, er);
            @(posedge clk);
            if (rst) begin
                m_w0 = (g0 >= 0);
                m_w1 = (g1 >= 0);
                if (g0 >= 0) begin
                    m_n0 = s_num[g0*AW +: AW];
                    m_d0 = s_data[g0*DW +: DW];
                    m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % N;
                end
                if (g1 >= 0) begin
                    m_n1 = s_num[g1*AW +: AW];
                    m_d1 = s_data[g1*DW +: DW];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] n, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_num[i*AW +: AW] = n;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic exp_ready(input string nm, input logic [N-1:0] e);
        @(negedge clk);
        check(nm, req_ready, e);
    endtask

    task automatic exp_out(input string nm, input logic w0, input logic [AW-1:0] n0, input logic [DW-1:0] d0,
                           input logic w1, input logic [AW-1:0] n1, input logic [DW-1:0] d1);
        check(nm, {write0, num_write0_out, data_write0_out, write1, num_write1_out, data_write1_out},
                  {w0, n0, d0, w1, n1, d1});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin : stim
        logic [N-1:0] granted;
        rst = 1'b0;
        tick();
        exp_ready("reset_ready", 4'b0000);
        exp_out("reset_out", 0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        rst = 1'b1;

        // single request
        set_req(1, 1, 3'd5, 16'h1234);
        exp_ready("single_ready", 4'b0010);
        tick();
        set_req(1, 0, 3'd0, 16'h0);
        exp_ready("single_idle", 4'b0000);
        exp_out("single_out", 1, 3'd5, 16'h1234, 0, 3'd0, 16'h0);
        tick();
        do_reset();

        // dual grant, pointer wraps back to 0
        set_req(0, 1, 3'd2, 16'hAAAA);
        set_req(3, 1, 3'd6, 16'h5555);
        exp_ready("dual_ready", 4'b1001);
        tick();
        set_req(0, 0, 3'd0, 16'h0);
        set_req(3, 0, 3'd0, 16'h0);
        exp_ready("dual_idle", 4'b0000);
        exp_out("dual_out", 1, 3'd2, 16'hAAAA, 1, 3'd6, 16'h5555);
        tick();

        // same-register conflict
        set_req(0, 1, 3'd3, 16'h0A0A);
        set_req(1, 1, 3'd3, 16'h0B0B);
        set_req(2, 1, 3'd4, 16'h0C0C);
        exp_ready("conf_ready", 4'b0101);
        tick();
        set_req(0, 0, 3'd0, 16'h0);
        set_req(2, 0, 3'd0, 16'h0);
        exp_ready("conf_ready2", 4'b0010);
        exp_out("conf_out", 1, 3'd3, 16'h0A0A, 1, 3'd4, 16'h0C0C);
        tick();
        set_req(1, 0, 3'd0, 16'h0);
        exp_ready("conf_idle", 4'b0000);
        exp_out("conf_out2", 1, 3'd3, 16'h0B0B, 0, 3'd4, 16'h0C0C);
        tick();
        do_reset();

        // fairness / wrap with all valid
        for (int i = 0; i < N; i++) set_req(i, 1, 3'(i + 1), 16'(16'h5000 + i));
        exp_ready("rr_ready0", 4'b0011);
        tick();
        exp_ready("rr_ready1", 4'b1100);
        exp_out("rr_out1", 1, 3'd1, 16'h5000, 1, 3'd2, 16'h5001);
        tick();
        exp_ready("rr_ready2", 4'b0011);
        exp_out("rr_out2", 1, 3'd3, 16'h5002, 1, 3'd4, 16'h5003);
        tick();

        // stall for three cycles, then resume at the held pointer (2)
        stall = 1'b1;
        exp_ready("stall_ready0", 4'b0000);
        exp_out("stall_out0", 1, 3'd1, 16'h5000, 1, 3'd2, 16'h5001);
        tick();
        exp_ready("stall_ready1", 4'b0000);
        exp_out("stall_out1", 0, 3'd1, 16'h5000, 0, 3'd2, 16'h5001);
        tick();
        exp_ready("stall_ready2", 4'b0000);
        exp_out("stall_out2", 0, 3'd1, 16'h5000, 0, 3'd2, 16'h5001);
        tick();
        stall = 1'b0;
        exp_ready("stall_resume", 4'b1100);
        exp_out("stall_out3", 0, 3'd1, 16'h5000, 0, 3'd2, 16'h5001);
        tick();

        // reset mid-grant drops the in-flight write; restart from requester 0
        rst = 1'b0;
        exp_ready("midrst_ready", 4'b0000);
        exp_out("midrst_out", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        tick();
        rst = 1'b1;
        exp_ready("postrst_ready", 4'b0011);
        tick();
        for (int i = 0; i < N; i++) set_req(i, 0, 3'd0, 16'h0);
        exp_ready("postrst_idle", 4'b0000);
        exp_out("postrst_out", 1, 3'd1, 16'h5000, 1, 3'd2, 16'h5001);
        tick();

        // randomized traffic; requesters hold until granted
        granted = '0;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 4) == 0);
            rst = !(c >= 1500 && c < 1502);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || granted[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1, 3'($urandom_range(0, 7)), 16'($urandom));
                    else
                        set_req(i, 0, req_num[i*AW +: AW], req_data[i*DW +: DW]);
                end
            end
            @(negedge clk);
            granted = req_valid & req_ready;
            tick();
        end
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
